// File: rtl/lsu_pipe.sv
// lsu_pipe: multi-cycle load-store unit over data memory, output registers and switch input.
// Misaligned memory accesses split into two word beats; each request gets one response pulse.
module lsu_pipe #(
    parameter int ADDR_W     = 12,
    parameter int DMEM_WORDS = 512,
    parameter int N_OUT      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsign_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic [31:0]           io_sw_i,
    output logic [N_OUT*32-1:0]   io_out_o
);
    localparam int IW = ADDR_W - 3;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    typedef enum logic [1:0] {T_MEM, T_OUT, T_SW} tgt_t;
    state_t         state_q;
    tgt_t           tgt_q, tgt_d;
    logic           we_q, uns_q, split_q, err_q;
    logic [1:0]     off_q, size_q;
    logic [31:0]    wdata_q;
    logic [IW-1:0]  idx_q;
    logic [5:0]     pidx_q;
    logic [31:0]    rd_q, lo_q, sw_meta_q, sw_q, rsp_rdata_q;
    logic           rsp_valid_q, rsp_err_q;
    logic [31:0]    out_q [N_OUT];
    logic [31:0]    mem_q [DMEM_WORDS];
    logic [1:0]     req_off;
    logic [3:0]     req_nib;
    logic [IW-1:0]  req_idx;
    logic [5:0]     req_pidx;
    logic           req_mis, mem_bad, fault_d;
    always_comb begin
        req_off  = req_addr_i[1:0];
        req_nib  = req_addr_i[ADDR_W-1 -: 4];
        req_idx  = req_addr_i[ADDR_W-2:2];
        req_pidx = req_addr_i[7:2];
        req_mis  = (req_size_i == 2'd1 && req_off[0]) || (req_size_i == 2'd2 && req_off != 2'd0);
        mem_bad  = 32'(req_idx) >= DMEM_WORDS || (req_mis && 32'(req_idx) + 1 >= DMEM_WORDS);
        tgt_d    = !req_addr_i[ADDR_W-1] ? T_MEM : req_nib == 4'h8 ? T_OUT : T_SW;
        fault_d  = req_size_i == 2'd3 || (tgt_d == T_MEM ? mem_bad :
                   req_mis || (req_nib == 4'h8 ? 32'(req_pidx) >= N_OUT :
                   req_nib != 4'h9 || req_pidx != 6'd0 || req_we_i));
    end
    logic [3:0]     mask, beat_be;
    logic [7:0]     be;
    logic [63:0]    wd, raw;
    logic [31:0]    prd, lw32, ext, beat_wd;
    logic [IW-1:0]  mem_idx;
    logic           beat, mem_we, mem_re;
    // Lanes past byte 3 spill into the second beat of a split access.
    always_comb begin
        mask    = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
        be      = {4'b0, mask} << off_q;
        wd      = {32'b0, wdata_q} << {off_q, 3'b0};
        beat    = state_q == BEAT0 || state_q == BEAT1;
        mem_we  = beat && tgt_q == T_MEM && we_q;
        mem_re  = beat && tgt_q == T_MEM && !we_q;
        mem_idx = state_q == BEAT1 ? idx_q + IW'(1) : idx_q;
        beat_be = state_q == BEAT1 ? be[7:4] : be[3:0];
        beat_wd = state_q == BEAT1 ? wd[63:32] : wd[31:0];
        prd     = sw_q;
        for (int k = 0; k < N_OUT; k++)
            if (tgt_q == T_OUT && pidx_q == 6'(k)) prd = out_q[k];
        raw     = state_q == RESP ? (split_q ? {rd_q, lo_q} : {32'b0, rd_q}) : {32'b0, prd};
        lw32    = 32'(raw >> {off_q, 3'b0});
        ext     = size_q == 2'd0 ? {{24{~uns_q & lw32[7]}}, lw32[7:0]} :
                  size_q == 2'd1 ? {{16{~uns_q & lw32[15]}}, lw32[15:0]} : lw32;
    end
    always_ff @(posedge clk_i) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (beat_be[b]) mem_q[mem_idx][8*b +: 8] <= beat_wd[8*b +: 8];
        if (mem_re) rd_q <= mem_q[mem_idx];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tgt_q       <= T_MEM;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            pidx_q      <= '0;
            lo_q        <= '0;
            sw_meta_q   <= '0;
            sw_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else begin
            sw_meta_q   <= io_sw_i;
            sw_q        <= sw_meta_q;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    uns_q   <= req_unsign_i;
                    off_q   <= req_off;
                    size_q  <= req_size_i;
                    wdata_q <= req_wdata_i;
                    idx_q   <= req_idx;
                    pidx_q  <= req_pidx;
                    tgt_q   <= tgt_d;
                    split_q <= req_mis && tgt_d == T_MEM;
                    err_q   <= fault_d;
                    state_q <= fault_d ? RESP : BEAT0;
                end
                BEAT0: begin
                    if (tgt_q == T_OUT && we_q)
                        for (int k = 0; k < N_OUT; k++)
                            for (int b = 0; b < 4; b++)
                                if (pidx_q == 6'(k) && be[b]) out_q[k][8*b +: 8] <= wd[8*b +: 8];
                    if (tgt_q != T_MEM || (we_q && !split_q)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : ext;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= split_q ? BEAT1 : RESP;
                    end
                end
                BEAT1: begin
                    lo_q        <= rd_q;
                    rsp_valid_q <= we_q;
                    state_q     <= we_q ? IDLE : RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= err_q ? '0 : ext;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign io_out_o[32*g +: 32] = out_q[g];
    end
endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: scoreboard bench for lsu_pipe with N_OUT=8.
module tb_lsu_pipe;
    localparam logic ST = 1'b1, LD = 1'b0;
    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SX = 2'd3;
    logic          clk_i = 1'b0, rst_ni = 1'b0, req_valid_i = 1'b0, req_we_i = 1'b0, req_unsign_i = 1'b0;
    logic [11:0]   req_addr_i = '0;
    logic [1:0]    req_size_i = '0;
    logic [31:0]   req_wdata_i = '0, io_sw_i = 32'h98765432;
    logic          req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0]   rsp_rdata_o;
    logic [255:0]  io_out_o;
    lsu_pipe #(.ADDR_W(12), .DMEM_WORDS(512), .N_OUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsign_i(req_unsign_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw_i), .io_out_o(io_out_o)
    );
    always #5 clk_i = ~clk_i;
    typedef struct { string tag; logic err; logic [31:0] data; int lat; } exp_t;
    exp_t   sb[$];
    exp_t   mon_e;
    int     n_tests = 0, n_fail = 0, n_exp = 0, n_rsp = 0;
    longint acc_t = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk_i) if (rsp_valid_o) begin
        if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
        else begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "_err"}, 32'(rsp_err_o), 32'(mon_e.err));
            check({mon_e.tag, "_data"}, rsp_rdata_o, mon_e.data);
            check({mon_e.tag, "_lat"}, 32'(($time - 5 - acc_t) / 10), 32'(mon_e.lat));
            n_rsp++;
        end
    end
    task automatic issue(input string tag, input logic we, input logic [11:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_we_i = we;
        req_addr_i = addr;
        req_size_i = size;
        req_unsign_i = uns;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        for (int i = 0; i < 20 && !req_ready_o; i++) begin @(negedge clk_i); #1; end
        if (!req_ready_o) check({tag, "_accept"}, 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        acc_t = $time;
        #1 req_valid_i = 1'b0;
    endtask
    task automatic send(input string tag, input logic we, input logic [11:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input logic err, input logic [31:0] data, input int lat);
        sb.push_back('{tag, err, data, lat});
        n_exp++;
        issue(tag, we, addr, size, uns, wdata);
        for (int i = 0; i < 10 && n_rsp < n_exp; i++) begin @(negedge clk_i); #1; end
        if (n_rsp < n_exp) begin
            check({tag, "_timeout"}, 32'(n_rsp), 32'(n_exp));
            sb.delete(0);
            n_rsp = n_exp;
        end
    endtask
    initial begin
        #12;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_out", 32'(|io_out_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        send("sw4",  ST, 12'h004, SW, 1'b0, 32'h12348678, 1'b0, 32'h0, 1);
        send("lb4",  LD, 12'h004, SB, 1'b0, 32'h0, 1'b0, 32'h00000078, 2);
        send("lh4",  LD, 12'h004, SH, 1'b0, 32'h0, 1'b0, 32'hFFFF8678, 2);
        send("lhu4", LD, 12'h004, SH, 1'b1, 32'h0, 1'b0, 32'h00008678, 2);
        send("lw4",  LD, 12'h004, SW, 1'b0, 32'h0, 1'b0, 32'h12348678, 2);
        send("sw8",  ST, 12'h008, SW, 1'b0, 32'hAABBCCDD, 1'b0, 32'h0, 1);
        send("lw6",  LD, 12'h006, SW, 1'b0, 32'h0, 1'b0, 32'hCCDD1234, 3);
        send("sh7",  ST, 12'h007, SH, 1'b0, 32'h0000BEEF, 1'b0, 32'h0, 2);
        send("lw4b", LD, 12'h004, SW, 1'b0, 32'h0, 1'b0, 32'hEF348678, 2);
        send("lw8b", LD, 12'h008, SW, 1'b0, 32'h0, 1'b0, 32'hAABBCCBE, 2);
        send("lbuB", LD, 12'h00B, SB, 1'b1, 32'h0, 1'b0, 32'h000000AA, 2);
        send("lbB",  LD, 12'h00B, SB, 1'b0, 32'h0, 1'b0, 32'hFFFFFFAA, 2);
        send("lhA",  LD, 12'h00A, SH, 1'b0, 32'h0, 1'b0, 32'hFFFFAABB, 2);
        send("p_sw0", ST, 12'h800, SW, 1'b0, 32'h12348678, 1'b0, 32'h0, 1);
        check("out0_a", io_out_o[31:0], 32'h12348678);
        send("p_lh_sw", LD, 12'h900, SH, 1'b0, 32'h0, 1'b0, 32'h00005432, 1);
        send("p_lw_sw", LD, 12'h900, SW, 1'b0, 32'h0, 1'b0, 32'h98765432, 1);
        send("p_sw13", ST, 12'h834, SW, 1'b0, 32'h1, 1'b1, 32'h0, 1);
        check("out0_b", io_out_o[31:0], 32'h12348678);
        check("out_rest_b", 32'(|io_out_o[255:32]), 32'd0);
        send("p_sh2", ST, 12'h802, SH, 1'b0, 32'h0000CAFE, 1'b0, 32'h0, 1);
        check("out0_c", io_out_o[31:0], 32'hCAFE8678);
        send("p_lb1", LD, 12'h801, SB, 1'b0, 32'h0, 1'b0, 32'hFFFFFF86, 1);
        send("p_sb7", ST, 12'h81C, SB, 1'b0, 32'h1234565A, 1'b0, 32'h0, 1);
        check("out7", io_out_o[255:224], 32'h0000005A);
        send("p_lw7", LD, 12'h81C, SW, 1'b0, 32'h0, 1'b0, 32'h0000005A, 1);
        send("sw10",  ST, 12'h010, SW, 1'b0, 32'h11223344, 1'b0, 32'h0, 1);
        send("sw7fc", ST, 12'h7FC, SW, 1'b0, 32'h5A5A5A5A, 1'b0, 32'h0, 1);
        send("e_size",  ST, 12'h010, SX, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1);
        send("e_sw7fe", ST, 12'h7FE, SW, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        send("e_lw7fe", LD, 12'h7FE, SW, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("e_sw900", ST, 12'h900, SW, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("e_lwA00", LD, 12'hA00, SW, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("e_swA00", ST, 12'hA00, SW, 1'b0, 32'h77777777, 1'b1, 32'h0, 1);
        send("e_lw802", LD, 12'h802, SW, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("e_lh901", LD, 12'h901, SH, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("e_lw904", LD, 12'h904, SW, 1'b0, 32'h0, 1'b1, 32'h0, 1);
        send("lw10",  LD, 12'h010, SW, 1'b0, 32'h0, 1'b0, 32'h11223344, 2);
        send("lw7fc", LD, 12'h7FC, SW, 1'b0, 32'h0, 1'b0, 32'h5A5A5A5A, 2);
        send("sw20",  ST, 12'h020, SW, 1'b0, 32'h01010101, 1'b0, 32'h0, 1);
        send("sw24",  ST, 12'h024, SW, 1'b0, 32'h02020202, 1'b0, 32'h0, 1);
        issue("rst_sw", ST, 12'h021, SW, 1'b0, 32'hFFFFFFFF);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready_o), 32'd1);
        check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_out", 32'(|io_out_o), 32'd0);
        #3 rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        #1;
        send("post_lw24", LD, 12'h024, SW, 1'b0, 32'h0, 1'b0, 32'h02020202, 2);
        send("post_lw4",  LD, 12'h004, SW, 1'b0, 32'h0, 1'b0, 32'hEF348678, 2);
        send("post_lw10", LD, 12'h010, SW, 1'b0, 32'h0, 1'b0, 32'h11223344, 2);
        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
